// File: rtl/uart_rx_sample_timer_pkg.sv
// Shared UART receive definitions: timer state encoding, prescale floor and width helper.
// The RX FSM imports the same package so both agree on the encoding.
package uart_rx_sample_timer_pkg;

    localparam int unsigned MIN_PRESCALE_DEF = 4;

    localparam logic IDLE = 1'b0;
    localparam logic RUN  = 1'b1;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/uart_rx_sample_timer_if.sv
// Control/status bundle between the RX FSM (master) and the oversampling bit timer (slave).
interface uart_rx_sample_timer_if #(
    parameter int unsigned PRESCALE_WIDTH = 6,
    parameter int unsigned BIT_CNT_WIDTH  = 4
);
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic [BIT_CNT_WIDTH-1:0]  frame_bits;
    logic                      start;
    logic                      abort;
    logic                      busy;
    logic [PRESCALE_WIDTH-1:0] edge_count;
    logic [BIT_CNT_WIDTH-1:0]  bit_count;
    logic                      sample_en;
    logic                      sample_last;
    logic                      bit_done;
    logic                      frame_done;
    logic                      cfg_error;

    modport master (
        output prescale, frame_bits, start, abort,
        input  busy, edge_count, bit_count, sample_en, sample_last, bit_done, frame_done,
               cfg_error
    );

    modport slave (
        input  prescale, frame_bits, start, abort,
        output busy, edge_count, bit_count, sample_en, sample_last, bit_done, frame_done,
               cfg_error
    );

endinterface

// File: rtl/uart_rx_sample_timer_mod_counter.sv
// Modulo counter: counts 0..modulus-1 while enabled, wrap flags the terminal count.
module uart_mod_counter #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    logic [WIDTH-1:0] count_q, count_d;

    // Callers guarantee modulus >= 1 whenever en can be high.
    assign wrap  = en && (count_q == modulus - WIDTH'(1));
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = wrap ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx_sample_timer.sv
// Oversampling bit timer: tracks edge-within-bit and bit-within-frame, decodes mid-bit
// sample strobes and bit/frame completion for the sampler and deserializer.
module uart_rx_sample_timer
    import uart_rx_sample_timer_pkg::*;
#(
    parameter int unsigned PRESCALE_WIDTH = 6,
    parameter int unsigned MAX_FRAME_BITS = 12,
    parameter int unsigned MIN_PRESCALE   = MIN_PRESCALE_DEF,
    parameter int unsigned BIT_CNT_WIDTH  = cnt_width(MAX_FRAME_BITS)
) (
    input logic                    clk,
    input logic                    reset,
    uart_rx_sample_timer_if.slave  bus
);

    logic                      state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic [BIT_CNT_WIDTH-1:0]  frame_bits_q;
    logic                      cfg_error_q;

    logic                      busy;
    logic                      cfg_ok;
    logic                      can_start;
    logic                      accept;
    logic                      reject;
    logic                      clr;
    logic                      bit_done;
    logic                      frame_done;
    logic [PRESCALE_WIDTH-1:0] edge_count;
    logic [BIT_CNT_WIDTH-1:0]  bit_count;
    logic [PRESCALE_WIDTH-1:0] mid;
    logic [PRESCALE_WIDTH-1:0] mid_lo;
    logic [PRESCALE_WIDTH-1:0] mid_hi;

    assign busy = (state_q == RUN);

    assign cfg_ok = (bus.prescale >= PRESCALE_WIDTH'(MIN_PRESCALE))
                 && (bus.frame_bits != '0)
                 && (bus.frame_bits <= BIT_CNT_WIDTH'(MAX_FRAME_BITS));

    // A start is only considered in IDLE or on the last cycle of a frame; abort drops it.
    assign can_start = !busy || frame_done;
    assign accept    = bus.start && !bus.abort && can_start && cfg_ok;
    assign reject    = bus.start && !bus.abort && can_start && !cfg_ok;
    assign clr       = bus.abort || accept;

    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = IDLE;
        end else if (accept) begin
            state_d = RUN;
        end else if (frame_done) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            prescale_q   <= '0;
            frame_bits_q <= '0;
            cfg_error_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_error_q <= reject;
            if (accept) begin
                prescale_q   <= bus.prescale;
                frame_bits_q <= bus.frame_bits;
            end
        end
    end

    uart_mod_counter #(
        .WIDTH (PRESCALE_WIDTH)
    ) u_edge_counter (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .en      (busy),
        .modulus (prescale_q),
        .count   (edge_count),
        .wrap    (bit_done)
    );

    uart_mod_counter #(
        .WIDTH (BIT_CNT_WIDTH)
    ) u_bit_counter (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .en      (bit_done),
        .modulus (frame_bits_q),
        .count   (bit_count),
        .wrap    (frame_done)
    );

    // Prescale >= 4 keeps mid-1 and mid+1 inside the bit, so no wrap-around here.
    assign mid    = prescale_q >> 1;
    assign mid_lo = mid - PRESCALE_WIDTH'(1);
    assign mid_hi = mid + PRESCALE_WIDTH'(1);

    assign bus.busy        = busy;
    assign bus.edge_count  = edge_count;
    assign bus.bit_count   = bit_count;
    assign bus.sample_en   = busy && (edge_count == mid_lo || edge_count == mid
                                      || edge_count == mid_hi);
    assign bus.sample_last = busy && (edge_count == mid_hi);
    assign bus.bit_done    = bit_done;
    assign bus.frame_done  = frame_done;
    assign bus.cfg_error   = cfg_error_q;

endmodule

// File: tb/tb_uart_rx_sample_timer.sv
// Self-checking bench for uart_rx_sample_timer against an arithmetic frame-timing model.
module tb_uart_rx_sample_timer;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    uart_rx_sample_timer_if #(
        .PRESCALE_WIDTH (6),
        .BIT_CNT_WIDTH  (4)
    ) bus ();

    uart_rx_sample_timer #(
        .PRESCALE_WIDTH (6),
        .MAX_FRAME_BITS (12),
        .MIN_PRESCALE   (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {busy, edge_count, bit_count, sample_en, sample_last, bit_done, frame_done, cfg_error}
    logic [15:0] obs;
    assign obs = {bus.busy, bus.edge_count, bus.bit_count, bus.sample_en, bus.sample_last,
                  bus.bit_done, bus.frame_done, bus.cfg_error};

    // Expected outputs k cycles into a frame of f bits with p edges per bit.
    function automatic logic [15:0] exp_run(input int k, input int p, input int f);
        int e;
        int b;
        int mid;
        logic se;
        logic sl;
        logic bd;
        logic fd;
        e   = k % p;
        b   = k / p;
        mid = p / 2;
        se  = (e >= mid - 1) && (e <= mid + 1);
        sl  = (e == mid + 1);
        bd  = (e == p - 1);
        fd  = bd && (b == f - 1);
        return {1'b1, 6'(e), 4'(b), se, sl, bd, fd, 1'b0};
    endfunction

    task automatic test_reset();
        logic [15:0] want;
        want = 16'h0000;
        @(negedge clk);
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL reset_hold got %h want %h", obs, want);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL reset_release got %h want %h", obs, want);
        end
    endtask

    // Full frame checked every cycle; perturb scrambles config inputs and fires stray starts.
    task automatic test_frame(input int p, input int f, input bit perturb);
        logic [15:0] want;
        @(negedge clk);
        bus.prescale   = 6'(p);
        bus.frame_bits = 4'(f);
        bus.start      = 1'b1;
        for (int k = 0; k < p * f; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            want = exp_run(k, p, f);
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL frame p=%0d f=%0d k=%0d got %h want %h", p, f, k, obs, want);
            end
            if (perturb) begin
                bus.prescale   = 6'($urandom_range(0, 63));
                bus.frame_bits = 4'($urandom_range(0, 15));
                bus.start      = (k != p * f - 1) && ($urandom_range(0, 3) == 0);
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        want = 16'h0000;
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL frame_end p=%0d f=%0d got %h want %h", p, f, obs, want);
        end
    endtask

    task automatic test_bad_cfg();
        int cfg_p [3] = '{3, 16, 16};
        int cfg_f [3] = '{10, 0, 13};
        logic [15:0] want;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.prescale   = 6'(cfg_p[i]);
            bus.frame_bits = 4'(cfg_f[i]);
            bus.start      = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            want = 16'h0001;
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL bad_cfg_pulse p=%0d f=%0d got %h want %h",
                         cfg_p[i], cfg_f[i], obs, want);
            end
            @(negedge clk);
            want = 16'h0000;
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL bad_cfg_after p=%0d f=%0d got %h want %h",
                         cfg_p[i], cfg_f[i], obs, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] want;
        @(negedge clk);
        bus.prescale   = 6'd16;
        bus.frame_bits = 4'd2;
        bus.start      = 1'b1;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            want = exp_run(k, 16, 2);
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL b2b_first k=%0d got %h want %h", k, obs, want);
            end
            if (k == 31) begin
                bus.prescale   = 6'd8;
                bus.frame_bits = 4'd2;
                bus.start      = 1'b1;
            end
        end
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            want = exp_run(k, 8, 2);
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL b2b_second k=%0d got %h want %h", k, obs, want);
            end
        end
        @(negedge clk);
        want = 16'h0000;
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL b2b_end got %h want %h", obs, want);
        end
    endtask

    task automatic test_abort();
        logic [15:0] want;
        @(negedge clk);
        bus.prescale   = 6'd16;
        bus.frame_bits = 4'd10;
        bus.start      = 1'b1;
        for (int k = 0; k <= 4 * 16 + 5; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            want = exp_run(k, 16, 10);
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL abort_run k=%0d got %h want %h", k, obs, want);
            end
        end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        want = 16'h0000;
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL abort_mid got %h want %h", obs, want);
        end
        // Abort together with start, once with a legal and once with an illegal config.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.prescale   = (i == 0) ? 6'd16 : 6'd2;
            bus.frame_bits = 4'd10;
            bus.start      = 1'b1;
            bus.abort      = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            bus.abort = 1'b0;
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL abort_with_start i=%0d got %h want %h", i, obs, want);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] want;
        @(negedge clk);
        bus.prescale   = 6'd8;
        bus.frame_bits = 4'd4;
        bus.start      = 1'b1;
        for (int k = 0; k <= 2 * 8 + 3; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            want = exp_run(k, 8, 4);
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL areset_run k=%0d got %h want %h", k, obs, want);
            end
        end
        #2;
        reset = 1'b0;
        #1;
        want = 16'h0000;
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL areset_immediate got %h want %h", obs, want);
        end
        @(negedge clk);
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL areset_held got %h want %h", obs, want);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL areset_release got %h want %h", obs, want);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            test_frame(int'($urandom_range(4, 63)), int'($urandom_range(1, 12)),
                       bit'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        reset          = 1'b0;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.prescale   = 6'd16;
        bus.frame_bits = 4'd10;
        test_reset();
        test_frame(16, 10, 1'b0);
        test_frame(5, 3, 1'b0);
        test_bad_cfg();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_frame(16, 10, 1'b1);
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
